// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one uart_tx serializer between two byte requesters.
// Requester 0 is the ram_rw host-protocol responder and requester 1 is the
// CPU console/debug source. Ownership is granted per packet, round-robin on
// ties. The grant is held until the packet's last byte is accepted, MAX_BURST
// bytes have been accepted, or the owner keeps its valid low for TIMEOUT
// consecutive cycles.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_data_i[k]         byte from requester k
//   req_vld_i[k]          requester k presents a byte
//   req_last_i[k]         presented byte ends requester k's packet
//   req_rdy_o[k]          requester k's byte accepted this cycle (with vld)
//   uart_tx_data_o        byte forwarded to uart_tx
//   uart_tx_data_vld_o    forwarded byte valid
//   uart_tx_data_rdy_i    uart_tx can accept a byte
//   grant_o               one-hot current owner, 0 when idle
//   timeout_o             one-cycle pulse after a grant is revoked by timeout
module uart_tx_arb #(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [1:0][7:0] req_data_i,
  input  logic [1:0]      req_vld_i,
  input  logic [1:0]      req_last_i,
  output logic [1:0]      req_rdy_o,
  output logic [7:0]      uart_tx_data_o,
  output logic            uart_tx_data_vld_o,
  input  logic            uart_tx_data_rdy_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);

  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam int unsigned IDLE_W  = $clog2(TIMEOUT + 1);

  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_owner_q, last_owner_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic                 timeout_q, timeout_d;

  logic own_vld;
  logic own_last;
  logic accept;

  // Owner-side view of the request, selected by the registered owner.
  assign own_vld  = req_vld_i[owner_q];
  assign own_last = req_last_i[owner_q];
  assign accept   = (state_q == ST_BUSY) & own_vld & uart_tx_data_rdy_i;

  // State register. last_owner resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= '0;
      idle_cnt_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state: arbitration in IDLE, release/timeout bookkeeping in BUSY.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    timeout_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req_vld_i) begin
          state_d     = ST_BUSY;
          // Tie goes to whoever did not own the previous grant.
          owner_d     = (&req_vld_i) ? ~last_owner_q : req_vld_i[1];
          burst_cnt_d = '0;
          idle_cnt_d  = '0;
        end
      end

      ST_BUSY: begin
        // Only cycles with the owner's valid low count toward the timeout.
        if (own_vld) begin
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end

        if (accept) begin
          burst_cnt_d = burst_cnt_q + BURST_W'(1);
          if (own_last || (burst_cnt_q == BURST_LAST)) begin
            state_d      = ST_IDLE;
            last_owner_d = owner_q;
          end
        end else if (!own_vld && (idle_cnt_q == IDLE_LAST)) begin
          state_d      = ST_IDLE;
          last_owner_d = owner_q;
          timeout_d    = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: pure mux of the owner's channel while BUSY, all zero in IDLE.
  always_comb begin
    req_rdy_o          = '0;
    uart_tx_data_o     = '0;
    uart_tx_data_vld_o = 1'b0;
    grant_o            = '0;

    if (state_q == ST_BUSY) begin
      uart_tx_data_o     = req_data_i[owner_q];
      uart_tx_data_vld_o = own_vld;
      req_rdy_o[owner_q] = uart_tx_data_rdy_i;
      grant_o[owner_q]   = 1'b1;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Testbench for uart_tx_arb: directed scenarios followed by randomized
// packet traffic, checked against a packet-level reference model.
module tb_uart_tx_arb;

  localparam int unsigned MAX_BURST = 4;
  localparam int unsigned TIMEOUT   = 8;
  localparam int unsigned MEM_D     = 64;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [1:0][7:0] req_data_i;
  logic [1:0]      req_vld_i;
  logic [1:0]      req_last_i;
  logic [1:0]      req_rdy_o;
  logic [7:0]      uart_tx_data_o;
  logic            uart_tx_data_vld_o;
  logic            uart_tx_data_rdy_i;
  logic [1:0]      grant_o;
  logic            timeout_o;

  uart_tx_arb #(
    .MAX_BURST (MAX_BURST),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .req_data_i         (req_data_i),
    .req_vld_i          (req_vld_i),
    .req_last_i         (req_last_i),
    .req_rdy_o          (req_rdy_o),
    .uart_tx_data_o     (uart_tx_data_o),
    .uart_tx_data_vld_o (uart_tx_data_vld_o),
    .uart_tx_data_rdy_i (uart_tx_data_rdy_i),
    .grant_o            (grant_o),
    .timeout_o          (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-requester byte streams (data + last flag) and their progress.
  logic [7:0] src_data [2][MEM_D];
  logic       src_last [2][MEM_D];
  int         src_len   [2];
  int         src_pos   [2];
  int         src_start [2];
  int         gap_cnt   [2];
  bit         hold      [2];

  // Observed traffic and expected sequences.
  logic [7:0] out_data [$];
  int         out_cyc  [$];
  int         fall_cyc [$];
  logic [1:0] grant_seq[$];
  logic [7:0] exp_q    [$];
  logic [1:0] exp_g    [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i              = 1'b1;
    req_vld_i          = '0;
    req_last_i         = '0;
    req_data_i         = '0;
    uart_tx_data_rdy_i = 1'b1;
    repeat (2) step();
    rst_i = 1'b0;
  endtask

  task automatic clr_src();
    for (int k = 0; k < 2; k++) begin
      src_len[k]   = 0;
      src_pos[k]   = 0;
      src_start[k] = 0;
    end
    exp_q.delete();
    exp_g.delete();
  endtask

  task automatic push_b(input int k, input logic [7:0] d, input logic l);
    src_data[k][src_len[k]] = d;
    src_last[k][src_len[k]] = l;
    src_len[k]++;
  endtask

  // Reference: bytes the next grant of requester k must carry -- up to and
  // including the next last byte, capped at MAX_BURST.
  function automatic int seg_len(input int k);
    int n = 0;
    for (int i = src_pos[k]; i < src_len[k]; i++) begin
      n++;
      if (src_last[k][i] || n == int'(MAX_BURST)) break;
    end
    return n;
  endfunction

  // Drives both sources and uart_tx_data_rdy_i, checks every cycle, and logs
  // accepted bytes. Entered and left just after a rising edge.
  task automatic run_engine(input bit rnd, input int max_cycles);
    int         cyc;
    int         seg_cnt;
    int         seg_exp;
    logic [1:0] pg;
    logic [1:0] pv;
    logic       lw;
    logic       o;
    logic       win;
    bit         done;
    cyc = 0; seg_cnt = 0; seg_exp = 0; pg = '0; pv = '0; lw = 1'b1; done = 1'b0;
    out_data.delete(); out_cyc.delete(); fall_cyc.delete(); grant_seq.delete();
    for (int k = 0; k < 2; k++) begin
      src_pos[k] = 0; hold[k] = 1'b0; gap_cnt[k] = 0;
    end
    while (!done) begin
      for (int k = 0; k < 2; k++) begin
        if (cyc >= src_start[k] && src_pos[k] < src_len[k]) begin
          if (!hold[k]) begin
            if (!rnd || gap_cnt[k] >= 3 || $urandom_range(0, 2) != 0) hold[k] = 1'b1;
            else gap_cnt[k]++;
          end
          req_vld_i[k]  = hold[k];
          req_data_i[k] = src_data[k][src_pos[k]];
          req_last_i[k] = src_last[k][src_pos[k]];
        end else begin
          req_vld_i[k]  = 1'b0;
          req_data_i[k] = 8'($urandom_range(0, 255));
          req_last_i[k] = 1'($urandom_range(0, 1));
        end
      end
      uart_tx_data_rdy_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;

      @(negedge clk_i);
      chk("eng timeout_o", 32'(timeout_o), 32'd0);
      if (grant_o != 2'b00 && pg == 2'b00) begin
        o = grant_o[1];
        chk("eng grant onehot", 32'(grant_o), o ? 32'd2 : 32'd1);
        win = (pv == 2'b11) ? ~lw : pv[1];
        if (pv != 2'b00) chk("eng arb winner", 32'(o), 32'(win));
        grant_seq.push_back(grant_o);
        lw      = o;
        seg_exp = seg_len(int'(o));
        seg_cnt = 0;
      end else if (grant_o == 2'b00 && pg != 2'b00) begin
        chk("eng grant length", 32'(seg_cnt), 32'(seg_exp));
        fall_cyc.push_back(cyc);
      end else if (grant_o != 2'b00) begin
        chk("eng grant stable", 32'(grant_o), 32'(pg));
      end

      if (grant_o != 2'b00) begin
        o = grant_o[1];
        chk("eng tx_vld", 32'(uart_tx_data_vld_o), 32'(req_vld_i[o]));
        chk("eng owner rdy", 32'(req_rdy_o[o]), 32'(uart_tx_data_rdy_i));
        chk("eng other rdy", 32'(req_rdy_o[!o]), 32'd0);
        if (req_vld_i[o] && req_rdy_o[o]) begin
          if (src_pos[o] < src_len[o]) begin
            chk("eng data", 32'(uart_tx_data_o), 32'(src_data[o][src_pos[o]]));
            out_data.push_back(uart_tx_data_o);
            out_cyc.push_back(cyc);
            src_pos[o]++;
            hold[o]    = 1'b0;
            gap_cnt[o] = 0;
            seg_cnt++;
          end else begin
            chk("eng extra byte", 32'(src_pos[o]), 32'(src_len[o] - 1));
          end
        end
      end else begin
        chk("eng idle outputs", {29'd0, uart_tx_data_vld_o, req_rdy_o}, 32'd0);
      end

      pg = grant_o;
      pv = req_vld_i;
      cyc++;
      if (src_pos[0] == src_len[0] && src_pos[1] == src_len[1] && grant_o == 2'b00) begin
        done = 1'b1;
      end else if (cyc >= max_cycles) begin
        chk("eng completion", 32'(src_pos[0] + src_pos[1]), 32'(src_len[0] + src_len[1]));
        done = 1'b1;
      end
      step();
    end
  endtask

  task automatic chk_seq(input string tag);
    chk(tag, 32'(out_data.size()), 32'(exp_q.size()));
    for (int i = 0; i < out_data.size() && i < exp_q.size(); i++) begin
      chk(tag, 32'(out_data[i]), 32'(exp_q[i]));
    end
    chk(tag, 32'(grant_seq.size()), 32'(exp_g.size()));
    for (int i = 0; i < grant_seq.size() && i < exp_g.size(); i++) begin
      chk(tag, 32'(grant_seq[i]), 32'(exp_g[i]));
    end
  endtask

  initial begin
    int bad;

    // Reset held with both requesters valid: nothing granted.
    rst_i              = 1'b1;
    req_vld_i          = 2'b11;
    req_last_i         = 2'b11;
    req_data_i         = {8'h34, 8'h12};
    uart_tx_data_rdy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("reset grant", 32'(grant_o), 32'd0);
      chk("reset outputs", {29'd0, uart_tx_data_vld_o, req_rdy_o}, 32'd0);
      chk("reset data", 32'(uart_tx_data_o), 32'd0);
      chk("reset timeout", 32'(timeout_o), 32'd0);
      step();
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post-reset idle", 32'(grant_o), 32'd0);
    step();
    @(negedge clk_i);
    chk("first tie grant", 32'(grant_o), 32'd1);
    chk("first tie data", 32'(uart_tx_data_o), 32'h12);
    chk("first tie rdy", 32'(req_rdy_o), 32'd1);

    // Single packet from requester 0.
    do_reset();
    clr_src();
    push_b(0, 8'h2a, 1'b0); push_b(0, 8'h00, 1'b0); push_b(0, 8'h0f, 1'b1);
    exp_q = '{8'h2a, 8'h00, 8'h0f};
    exp_g = '{2'b01};
    run_engine(1'b0, 200);
    chk_seq("single packet");
    if (out_cyc.size() == 3 && fall_cyc.size() >= 1)
      chk("single release timing", 32'(fall_cyc[0]), 32'(out_cyc[2] + 1));
    else
      chk("single release count", 32'(fall_cyc.size()), 32'd1);

    // Round-robin between two continuous 2-byte streams.
    do_reset();
    clr_src();
    for (int p = 0; p < 2; p++) begin
      push_b(0, 8'haa, 1'b0); push_b(0, 8'hbb, 1'b1);
      push_b(1, 8'hcc, 1'b0); push_b(1, 8'hdd, 1'b1);
    end
    exp_q = '{8'haa, 8'hbb, 8'hcc, 8'hdd, 8'haa, 8'hbb, 8'hcc, 8'hdd};
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    run_engine(1'b0, 200);
    chk_seq("round robin");

    // Burst limit: long r1 packet is split around r0's packet.
    do_reset();
    clr_src();
    for (int i = 0; i < 6; i++) push_b(1, 8'(8'hb0 + i), (i == 5));
    push_b(0, 8'h11, 1'b0); push_b(0, 8'h22, 1'b1);
    src_start[0] = 2;
    exp_q = '{8'hb0, 8'hb1, 8'hb2, 8'hb3, 8'h11, 8'h22, 8'hb4, 8'hb5};
    exp_g = '{2'b10, 2'b01, 2'b10};
    run_engine(1'b0, 200);
    chk_seq("burst limit");

    // Timeout: r0 sends one byte without last, then goes quiet.
    do_reset();
    req_vld_i  = 2'b11;
    req_data_i = {8'h66, 8'h55};
    req_last_i = 2'b10;
    @(negedge clk_i);
    chk("to idle", 32'(grant_o), 32'd0);
    step();
    @(negedge clk_i);
    chk("to grant r0", 32'(grant_o), 32'd1);
    chk("to data", 32'(uart_tx_data_o), 32'h55);
    chk("to rdy", 32'(req_rdy_o), 32'd1);
    step();
    req_vld_i[0] = 1'b0;
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      @(negedge clk_i);
      chk("to held", 32'(grant_o), 32'd1);
      chk("to early pulse", 32'(timeout_o), 32'd0);
      step();
    end
    @(negedge clk_i);
    chk("to pulse", 32'(timeout_o), 32'd1);
    chk("to revoked", 32'(grant_o), 32'd0);
    chk("to revoked rdy", 32'(req_rdy_o), 32'd0);
    step();
    @(negedge clk_i);
    chk("to pulse width", 32'(timeout_o), 32'd0);
    chk("to next owner", 32'(grant_o), 32'd2);
    chk("to next data", 32'(uart_tx_data_o), 32'h66);

    // Backpressure: long rdy-low stall with owner valid never times out.
    do_reset();
    req_vld_i          = 2'b01;
    req_data_i         = {8'h00, 8'h77};
    req_last_i         = 2'b01;
    uart_tx_data_rdy_i = 1'b0;
    step();
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_i);
      if (grant_o !== 2'b01 || timeout_o !== 1'b0 || uart_tx_data_vld_o !== 1'b1 ||
          req_rdy_o !== 2'b00 || uart_tx_data_o !== 8'h77) bad++;
      step();
    end
    chk("bp stall cycles", 32'(bad), 32'd0);
    uart_tx_data_rdy_i = 1'b1;
    @(negedge clk_i);
    chk("bp accept", 32'(req_rdy_o), 32'd1);
    chk("bp accept data", 32'(uart_tx_data_o), 32'h77);
    step();
    req_vld_i = 2'b00;
    @(negedge clk_i);
    chk("bp release", 32'(grant_o), 32'd0);
    chk("bp no timeout", 32'(timeout_o), 32'd0);
    step();

    // Randomized packets, gaps and backpressure.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      clr_src();
      for (int k = 0; k < 2; k++) begin
        while (src_len[k] < 30) begin
          int plen;
          plen = $urandom_range(1, 7);
          for (int b = 0; b < plen; b++) push_b(k, 8'($urandom_range(0, 255)), (b == plen - 1));
        end
        src_start[k] = $urandom_range(0, 3);
      end
      run_engine(1'b1, 3000);
      chk("rand byte count", 32'(out_data.size()), 32'(src_len[0] + src_len[1]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
